// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial add/subtract sequencer.
package multiword_add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/multiword_add_seq_rca4.sv
// Four-bit ripple-carry adder slice reused by the sequencer for every nibble.
module RippleCarryAdder4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    always_comb begin
        logic carry;
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared 4-bit adder slice,
// processing one nibble per cycle with the carry held in a register between steps.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] sliceA, sliceB, sliceSum;
    logic                sliceCout;
    logic [WIDTH-1:0]    workMerged;

    assign sliceA = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign sliceB = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    RippleCarryAdder4bit u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // Working register with the current nibble already replaced, so the commit
    // edge can publish the complete word in one step.
    always_comb begin
        workMerged = work_q;
        workMerged[idx_q*NIBBLE_W +: NIBBLE_W] = sliceSum;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is A + ~B + 1, so only B and the initial carry differ.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d  = workMerged;
                carry_d = sliceCout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d = workMerged;
                    cout_d   = sliceCout;
                    ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (workMerged[WIDTH-1] != a_q[WIDTH-1]);
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
